// File: rtl/uart_disp_cmd_ctrl.sv
// uart_disp_cmd_ctrl
// Consumes bytes from the UART receiver's toggle handshake and parses fixed
// 4-byte frames (sync, command, payload, checksum). Good frames update the
// digit, decimal-point and blank registers that feed the display scanner.
// Rejected frames and inter-byte timeouts raise cmd_err and are counted.
module uart_disp_cmd_ctrl #(
  parameter int         DIGITS       = 8,
  parameter int         TIMEOUT_CLKS = 208320,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_toggle,
  output logic [4*DIGITS-1:0]   digit_data,
  output logic [DIGITS-1:0]     dp,
  output logic                  blank,
  output logic                  frame_busy,
  output logic                  cmd_ok,
  output logic                  cmd_err,
  output logic [7:0]            err_count
);

  localparam logic [7:0]  DIGITS_B  = 8'(DIGITS);
  localparam logic [23:0] TMO_LIMIT = 24'(TIMEOUT_CLKS);
  localparam logic [7:0]  CMD_BLANK = 8'h40;
  localparam logic [7:0]  CMD_CLEAR = 8'h41;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_CMD  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        tog_q;
  logic        byte_valid;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  pay_q, pay_d;
  logic [23:0] tmo_q, tmo_d;
  logic        timeout_hit;
  logic        cmd_legal;
  logic        chk_match;
  logic        exec_ok;
  logic        exec_err;

  logic [3:0]        digit_q [DIGITS];
  logic [3:0]        digit_d [DIGITS];
  logic [DIGITS-1:0] dp_q, dp_d;
  logic              blank_q, blank_d;
  logic              busy_q;
  logic              ok_q;
  logic              err_q;
  logic [7:0]        errcnt_q, errcnt_d;

  // Delay the receiver toggle by one cycle so any edge becomes a byte strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      tog_q <= 1'b0;
    end else begin
      tog_q <= rx_toggle;
    end
  end

  assign byte_valid  = rx_toggle ^ tog_q;
  assign cmd_legal   = (cmd_q < DIGITS_B) || (cmd_q == CMD_BLANK) || (cmd_q == CMD_CLEAR);
  assign chk_match   = (rx_data == (cmd_q ^ pay_q));
  // A byte landing on the limit cycle takes precedence over the timeout
  assign timeout_hit = (state_q != S_SYNC) && !byte_valid && (tmo_q == TMO_LIMIT);

  // Frame parser: next state, field latches and execute/reject decision
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pay_d    = pay_q;
    exec_ok  = 1'b0;
    exec_err = 1'b0;
    case (state_q)
      S_SYNC: begin
        // Anything other than the sync marker is line noise; drop it quietly
        if (byte_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (byte_valid) begin
          cmd_d   = rx_data;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (byte_valid) begin
          pay_d   = rx_data;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (byte_valid) begin
          state_d = S_SYNC;
          if (chk_match && cmd_legal) begin
            exec_ok = 1'b1;
          end else begin
            exec_err = 1'b1;
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
    if (timeout_hit) begin
      state_d  = S_SYNC;
      exec_err = 1'b1;
    end
  end

  // Inter-byte timer: idle in S_SYNC, restarted by every received byte
  always_comb begin
    tmo_d = tmo_q + 24'd1;
    if (byte_valid || (state_q == S_SYNC) || timeout_hit) begin
      tmo_d = 24'd0;
    end
  end

  // Command execution into the display registers
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit_d[i] = digit_q[i];
    end
    dp_d    = dp_q;
    blank_d = blank_q;
    if (exec_ok) begin
      if (cmd_q < DIGITS_B) begin
        // Payload bits [6:4] carry nothing for a digit write
        for (int i = 0; i < DIGITS; i++) begin
          if (cmd_q == 8'(i)) begin
            digit_d[i] = pay_q[3:0];
            dp_d[i]    = pay_q[7];
          end
        end
      end else if (cmd_q == CMD_BLANK) begin
        blank_d = pay_q[0];
      end else begin
        // Clear leaves the blank control alone
        for (int i = 0; i < DIGITS; i++) begin
          digit_d[i] = 4'd0;
        end
        dp_d = '0;
      end
    end
  end

  // Saturating error counter
  always_comb begin
    errcnt_d = errcnt_q;
    if (exec_err && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // Parser state, latched fields and inter-byte timer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_SYNC;
      cmd_q   <= 8'd0;
      pay_q   <= 8'd0;
      tmo_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      pay_q   <= pay_d;
      tmo_q   <= tmo_d;
    end
  end

  // Display registers, status pulses and error count
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= 4'd0;
      end
      dp_q     <= '0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= digit_d[i];
      end
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      busy_q   <= (state_d != S_SYNC);
      ok_q     <= exec_ok;
      err_q    <= exec_err;
      errcnt_q <= errcnt_d;
    end
  end

  // Pack the digit registers into the scanner bus, digit n at [4n+3:4n]
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit_out
    assign digit_data[4*gi +: 4] = digit_q[gi];
  end

  assign dp         = dp_q;
  assign blank      = blank_q;
  assign frame_busy = busy_q;
  assign cmd_ok     = ok_q;
  assign cmd_err    = err_q;
  assign err_count  = errcnt_q;

endmodule
